// File: rtl/input_port_buffer.sv
// Router input stage: flit FIFO with XY route lock held from head to tail flit.
// Optional feature: define INPORT_ERRCNT_EN to count malformed flits dropped while idle.
module input_port_buffer #(
  parameter logic [3:0] addr_sw = 4'b0000,
  parameter int         DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] flit_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [31:0] flit_out,
  output logic        valid_out,
  output logic [4:0]  req,
  input  logic        grant,
  output logic [7:0]  err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  // state | meaning
  // IDLE  | no route held; front flit is routed or dropped if malformed
  // ROUTED| route locked; flits forwarded on grant until tail/single leaves
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ROUTED = 1'b1;

  localparam logic [1:0] T_SINGLE = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b11;

  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [0:0]    state;
  logic [4:0]    req_q;

  logic [31:0] front;
  logic [1:0]  front_type;
  logic        empty, full, push, pop, drop, is_head, is_close;
  logic [4:0]  route_req;

  always_comb begin
    front      = mem[rd_ptr];
    front_type = front[31:30];
    empty      = (count == '0);
    full       = (count == FULL_CNT);
    is_head    = (front_type == T_SINGLE) || (front_type == T_HEAD);
    is_close   = (front_type == T_SINGLE) || (front_type == T_TAIL);
    ready_out  = !full;
    valid_out  = (state == ST_ROUTED) && !empty;
    flit_out   = front;
    req        = req_q;
    push       = valid_in && !full;
    drop       = (state == ST_IDLE) && !empty && !is_head;
    pop        = (valid_out && grant) || drop;
  end

  // XY dimension-order routing: resolve X first, then Y, else local
  always_comb begin
    route_req = 5'b10000;
    if (front[29:28] > addr_sw[3:2])      route_req = 5'b00010;
    else if (front[29:28] < addr_sw[3:2]) route_req = 5'b01000;
    else if (front[27:26] > addr_sw[1:0]) route_req = 5'b00100;
    else if (front[27:26] < addr_sw[1:0]) route_req = 5'b00001;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= flit_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= ST_IDLE;
      req_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      case (state)
        ST_IDLE: begin
          if (!empty && is_head) begin
            state <= ST_ROUTED;
            req_q <= route_req;
          end
        end
        default: begin
          // A stray head inside a packet is forwarded without releasing the lock
          if (valid_out && grant && is_close) begin
            state <= ST_IDLE;
            req_q <= '0;
          end
        end
      endcase
    end
  end

`ifdef INPORT_ERRCNT_EN
  logic [7:0] err_q;
  always_ff @(posedge clk) begin
    if (rst)                          err_q <= '0;
    else if (drop && err_q != 8'hFF)  err_q <= err_q + 8'd1;
  end
  assign err_cnt = err_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_input_port_buffer.sv
// Self-checking bench for input_port_buffer: queue-based packet model plus directed and random traffic.
module tb_input_port_buffer;
  localparam logic [3:0] ADDR = 4'b0101;
  localparam int         DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, valid_in, grant;
  logic [31:0] flit_in;
  logic        ready_out, valid_out;
  logic [31:0] flit_out;
  logic [4:0]  req;
  logic [7:0]  err_cnt;

  input_port_buffer #(.addr_sw(ADDR), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flit_in(flit_in), .valid_in(valid_in),
    .ready_out(ready_out), .flit_out(flit_out), .valid_out(valid_out),
    .req(req), .grant(grant), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a packet queue, a lock flag and the latched route
  logic [31:0] q[$];
  bit          locked = 0;
  logic [4:0]  m_req = '0;
  int          m_err = 0;
  bit          m_push, m_pop, m_unlock;
  logic [1:0]  m_type;

  function automatic logic [4:0] route(logic [3:0] d);
    int dx, dy, x, y;
    dx = int'(d[3:2]); dy = int'(d[1:0]);
    x = int'(ADDR[3:2]); y = int'(ADDR[1:0]);
    if (dx > x) return 5'b00010;
    if (dx < x) return 5'b01000;
    if (dy > y) return 5'b00100;
    if (dy < y) return 5'b00001;
    return 5'b10000;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      locked = 0;
      m_req = '0;
      m_err = 0;
    end else begin
      m_push = valid_in && (q.size() < DEPTH);
      m_pop = 0;
      m_unlock = 0;
      if (q.size() > 0) begin
        m_type = q[0][31:30];
        if (locked) begin
          if (grant) begin
            m_pop = 1;
            m_unlock = (m_type == 2'b00) || (m_type == 2'b11);
          end
        end else if (m_type == 2'b00 || m_type == 2'b01) begin
          locked = 1;
          m_req = route(q[0][29:26]);
        end else begin
          m_pop = 1;
`ifdef INPORT_ERRCNT_EN
          if (m_err < 255) m_err++;
`endif
        end
      end
      if (m_pop) void'(q.pop_front());
      if (m_unlock) begin
        locked = 0;
        m_req = '0;
      end
      if (m_push) q.push_back(flit_in);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("ready_out", 32'(ready_out), 32'(q.size() < DEPTH));
      chk("valid_out", 32'(valid_out), 32'(locked && q.size() > 0));
      chk("req", 32'(req), 32'(m_req));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      if (locked && q.size() > 0) chk("flit_out", flit_out, q[0]);
    end
  end

  function automatic logic [31:0] mk(logic [1:0] t, logic [3:0] dest, logic [21:0] pl);
    return {t, dest, 4'h0, pl};
  endfunction

  logic [31:0] f [5];
  logic [31:0] s_flit;

  initial begin
    rst = 1; valid_in = 0; grant = 0; flit_in = '0;
    @(posedge clk);
    armed = 1;
    @(negedge clk);
    @(negedge clk);
    // 1: reset values
    chk("rst_ready", 32'(ready_out), 32'd1);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    rst = 0;

    // 2: single flit addressed to this router goes local
    @(negedge clk);
    s_flit = mk(2'b00, 4'b0101, 22'h1);
    valid_in = 1; flit_in = s_flit; grant = 1;
    @(negedge clk); valid_in = 0;
    @(negedge clk);
    chk("t2_req", 32'(req), 32'b10000);
    chk("t2_valid", 32'(valid_out), 32'd1);
    chk("t2_flit", flit_out, s_flit);
    @(negedge clk);
    chk("t2_req_clr", 32'(req), 32'd0);
    chk("t2_valid_clr", 32'(valid_out), 32'd0);

    // 3: three-flit packet eastbound
    f[0] = mk(2'b01, 4'b1000, 22'h11);
    f[1] = {2'b10, 30'h0000_0222};
    f[2] = {2'b11, 30'h0000_0333};
    valid_in = 1; flit_in = f[0];
    @(negedge clk); flit_in = f[1];
    @(negedge clk); flit_in = f[2];
    chk("t3_req0", 32'(req), 32'b00010);
    chk("t3_flit0", flit_out, f[0]);
    @(negedge clk); valid_in = 0;
    chk("t3_req1", 32'(req), 32'b00010);
    chk("t3_flit1", flit_out, f[1]);
    @(negedge clk);
    chk("t3_req2", 32'(req), 32'b00010);
    chk("t3_flit2", flit_out, f[2]);
    @(negedge clk);
    chk("t3_req_clr", 32'(req), 32'd0);

    // 4: fill to full with grant low; fifth flit must be refused
    grant = 0;
    f[0] = mk(2'b01, 4'b0001, 22'h40);
    for (int i = 1; i < 5; i++) f[i] = {2'b10, 30'(32'h100 + i)};
    for (int i = 0; i < 5; i++) begin
      valid_in = 1; flit_in = f[i];
      @(negedge clk);
    end
    chk("t4_full", 32'(ready_out), 32'd0);
    valid_in = 0; grant = 1;
    @(negedge clk);
    chk("t4_ready_back", 32'(ready_out), 32'd1);
    chk("t4_order", flit_out, f[1]);
    repeat (3) @(negedge clk);
    chk("t4_drained", 32'(valid_out), 32'd0);
    valid_in = 1; flit_in = {2'b11, 30'h0000_0444};
    @(negedge clk); valid_in = 0;
    repeat (2) @(negedge clk);
    chk("t4_closed", 32'(req), 32'd0);

    // 5: body flit while idle is dropped
    valid_in = 1; flit_in = 32'h8000_00AA; grant = 0;
    @(negedge clk); valid_in = 0;
    chk("t5_valid0", 32'(valid_out), 32'd0);
    @(negedge clk);
    chk("t5_valid1", 32'(valid_out), 32'd0);
`ifdef INPORT_ERRCNT_EN
    chk("t5_err", 32'(err_cnt), 32'd1);
`else
    chk("t5_err", 32'(err_cnt), 32'd0);
`endif

    // error counter saturation
    for (int i = 0; i < 300; i++) begin
      valid_in = 1; flit_in = {2'b10, 30'(i)};
      @(negedge clk);
    end
    valid_in = 0;
    repeat (2) @(negedge clk);
`ifdef INPORT_ERRCNT_EN
    chk("err_sat", 32'(err_cnt), 32'hFF);
`else
    chk("err_sat", 32'(err_cnt), 32'h00);
`endif

    // 6: reset mid-packet
    valid_in = 1; flit_in = mk(2'b01, 4'b0000, 22'h66);
    @(negedge clk); flit_in = {2'b10, 30'h666};
    @(negedge clk); valid_in = 0; rst = 1;
    @(negedge clk); rst = 0;
    chk("t6_valid", 32'(valid_out), 32'd0);
    chk("t6_req", 32'(req), 32'd0);
    chk("t6_ready", 32'(ready_out), 32'd1);

    // random traffic with mostly well-formed packets and rare resets
    for (int i = 0; i < 4000; i++) begin
      logic [1:0] t;
      int r;
      r = int'($urandom_range(0, 9));
      t = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
      valid_in = ($urandom_range(0, 3) != 0);
      flit_in = {t, 4'($urandom_range(0, 15)), 26'($urandom)};
      grant = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst = 0; valid_in = 0; grant = 0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
